next_sequencer: RTL and testbench

Run controller at the front of the binary-CNN pipeline. Conditions the raw active-low NEXT push-button, issues one single-cycle `next` start pulse per press to input_layer and the downstream layers, and locks out further presses until output_layer reports completion. Captures the classification result for display and flags runs that never finish.

---
 rtl/bcnn_pkg.sv | 21 ++
 rtl/next_sequencer_if.sv | 34 +++
 rtl/next_sequencer_button_debounce.sv | 65 ++++++
 rtl/next_sequencer.sv | 96 +++++++++
 tb/tb_next_sequencer.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcnn_pkg.sv
// ---------------------------------------------------------------------------
// bcnn_pkg
// Shared definitions for the binary-CNN front-end run controller.
//   CLASS_W              width of a class index (0..9 fits in 4 bits)
//   class_t              class-index type carried on the result bus
//   DEF_DEBOUNCE_CYCLES  default debounce length for the NEXT button
//   DEF_TIMEOUT_CYCLES   default run limit before a run is abandoned
//   ST_IDLE / ST_RUN     sequencer FSM encoding
// ---------------------------------------------------------------------------
package bcnn_pkg;

   localparam int CLASS_W             = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_TIMEOUT_CYCLES  = 4096;

   typedef logic [CLASS_W-1:0] class_t;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/next_sequencer_if.sv
// ---------------------------------------------------------------------------
// next_sequencer_if
// Bundle between the run controller and the CNN layers / display.
//   output_finish  completion level from output_layer
//   output_result  class index from output_layer, valid when finish rises
//   next           one-cycle start pulse to all layers
//   busy           a run is in progress
//   result         latched class index of the last completed run
//   result_valid   result holds a completed run's answer
//   timeout        the last run was abandoned
// master: the sequencer side.  slave: the layer / display side.
// ---------------------------------------------------------------------------
interface next_sequencer_if;
   import bcnn_pkg::*;

   logic   output_finish;
   class_t output_result;
   logic   next;
   logic   busy;
   class_t result;
   logic   result_valid;
   logic   timeout;

   modport master (
      input  output_finish, output_result,
      output next, busy, result, result_valid, timeout
   );

   modport slave (
      output output_finish, output_result,
      input  next, busy, result, result_valid, timeout
   );

endinterface

// File: rtl/next_sequencer_button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Conditions the raw active-low NEXT push-button.
//   CLK    system clock
//   NRST   synchronous active-low reset
//   NEXT   raw button, asynchronous to CLK, bouncy
//   press  one-cycle pulse after the debounced level falls (button pressed)
// The debounced level flips only after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive edges; any agreeing sample
// restarts the count, so bounces never reach the press output.
// ---------------------------------------------------------------------------
module button_debounce
   import bcnn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic CLK,
   input  logic NRST,
   input  logic NEXT,
   output logic press
);

   localparam int            DW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DLIM = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync_a;
   logic          sync;
   logic          deb;
   logic          deb_q;
   logic [DW-1:0] dcnt;

   // Reset to the released (high) level everywhere so a reset never
   // manufactures a press by itself.
   always_ff @(posedge CLK) begin
      // NOTE: reset is synchronous, so it is tested inside the clocked block
      // and never appears in the sensitivity list.
      if (!NRST) begin
         sync_a <= 1'b1;
         sync   <= 1'b1;
         deb    <= 1'b1;
         deb_q  <= 1'b1;
         dcnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments let sync_a -> sync form a true
         // two-stage chain; blocking ones would collapse it into one stage.
         sync_a <= NEXT;
         sync   <= sync_a;
         deb_q  <= deb;
         if (sync != deb) begin
            if (dcnt == DLIM) begin
               deb  <= sync;
               dcnt <= '0;
            end else begin
               dcnt <= dcnt + 1'b1;
            end
         end else begin
            dcnt <= '0;
         end
      end
   end

   // Falling edge of the debounced level; release edges are ignored.
   assign press = deb_q & ~deb;

endmodule

// File: rtl/next_sequencer.sv
// ---------------------------------------------------------------------------
// next_sequencer
// Run controller at the front of the binary-CNN pipeline.
//   CLK   system clock
//   NRST  synchronous active-low reset
//   NEXT  raw active-low push-button
//   bus   next_sequencer_if.master: finish/result in, next/busy/result/
//         result_valid/timeout out
// A debounced press in IDLE issues one next pulse and starts a run. The run
// ends on a rising edge of output_finish (result latched) or after
// TIMEOUT_CYCLES cycles (timeout flagged, result kept). Presses during a run
// are dropped, not queued.
// ---------------------------------------------------------------------------
module next_sequencer
   import bcnn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
   input  logic CLK,
   input  logic NRST,
   input  logic NEXT,
   next_sequencer_if.master bus
);

   localparam int            TW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

   logic          press;
   logic [0:0]    state;
   logic [TW-1:0] tcnt;
   logic          fin_s;
   logic          fin_q;
   logic          fin_edge;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .CLK   (CLK),
      .NRST  (NRST),
      .NEXT  (NEXT),
      .press (press)
   );

   // Finish is sampled once, then compared with the previous sample. Both
   // reset to 1 so a finish level already high at reset is not an edge.
   assign fin_edge = fin_s & ~fin_q;

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         state            <= ST_IDLE;
         tcnt             <= '0;
         fin_s            <= 1'b1;
         fin_q            <= 1'b1;
         bus.next         <= 1'b0;
         bus.busy         <= 1'b0;
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         bus.timeout      <= 1'b0;
      end else begin
         fin_s    <= bus.output_finish;
         fin_q    <= fin_s;
         bus.next <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Finish edges arriving while idle fall through untouched.
               if (press) begin
                  bus.next         <= 1'b1;
                  bus.busy         <= 1'b1;
                  bus.result_valid <= 1'b0;
                  bus.timeout      <= 1'b0;
                  tcnt             <= '0;
                  state            <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Finish has priority over both the limit and a new press.
               if (fin_edge) begin
                  bus.result       <= bus.output_result;
                  bus.result_valid <= 1'b1;
                  bus.busy         <= 1'b0;
                  state            <= ST_IDLE;
               end else if (tcnt == TLIM) begin
                  bus.timeout <= 1'b1;
                  bus.busy    <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_next_sequencer.sv
// ---------------------------------------------------------------------------
// tb_next_sequencer
// Two sequencers share one button and one finish/result source: dut_d uses
// the default parameters, dut_t a 16-cycle run limit. A behavioural model
// expressed in edge numbers (how long the synchronized button has disagreed
// with the debounced level, how long a run has lasted) predicts every output
// of both each cycle. Scenario tasks add directed timing checks.
// ---------------------------------------------------------------------------
module tb_next_sequencer;
   import bcnn_pkg::*;

   localparam int DEB   = 4;
   localparam int LIM_D = 4096;
   localparam int LIM_T = 16;

   logic       CLK;
   logic       NRST;
   logic       NEXT;
   logic       fin;
   logic [3:0] res;

   int vectors;
   int miscompares;

   next_sequencer_if bus_d ();
   next_sequencer_if bus_t ();

   assign bus_d.output_finish = fin;
   assign bus_d.output_result = res;
   assign bus_t.output_finish = fin;
   assign bus_t.output_result = res;

   next_sequencer dut_d (
      .CLK  (CLK),
      .NRST (NRST),
      .NEXT (NEXT),
      .bus  (bus_d)
   );

   next_sequencer #(
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (LIM_T)
   ) dut_t (
      .CLK  (CLK),
      .NRST (NRST),
      .NEXT (NEXT),
      .bus  (bus_t)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   int         edge_no;
   bit         m_s1, m_s2, m_deb, m_press, m_f1, m_f2;
   int         m_agree;       // last edge where the synced button matched deb
   bit         m_next  [2];
   bit         m_busy  [2];
   logic [3:0] m_res   [2];
   bit         m_rv    [2];
   bit         m_to    [2];
   int         m_start [2];   // edge at which the current run began

   function automatic int lim(int k);
      return (k == 0) ? LIM_D : LIM_T;
   endfunction

   task automatic model_step();
      bit sync_now, press_now, fedge;
      edge_no++;
      if (!NRST) begin
         m_s1 = 1; m_s2 = 1; m_deb = 1; m_press = 0; m_f1 = 1; m_f2 = 1;
         m_agree = edge_no;
         for (int k = 0; k < 2; k++) begin
            m_next[k] = 0; m_busy[k] = 0; m_res[k] = '0;
            m_rv[k] = 0; m_to[k] = 0; m_start[k] = 0;
         end
         return;
      end
      sync_now  = m_s2;
      press_now = m_press;
      fedge     = m_f1 & ~m_f2;
      m_press   = 0;
      if (sync_now == m_deb) begin
         m_agree = edge_no;
      end else if (edge_no - m_agree == DEB) begin
         m_deb   = sync_now;
         m_press = !sync_now;
         m_agree = edge_no;
      end
      m_s2 = m_s1; m_s1 = NEXT;
      m_f2 = m_f1; m_f1 = fin;
      for (int k = 0; k < 2; k++) begin
         m_next[k] = 0;
         if (!m_busy[k]) begin
            if (press_now) begin
               m_next[k] = 1; m_busy[k] = 1; m_rv[k] = 0; m_to[k] = 0;
               m_start[k] = edge_no;
            end
         end else if (fedge) begin
            m_res[k] = res; m_rv[k] = 1; m_busy[k] = 0;
         end else if (edge_no - m_start[k] == lim(k)) begin
            m_to[k] = 1; m_busy[k] = 0;
         end
      end
   endtask

   function automatic logic [15:0] dut_vec();
      return {bus_d.next, bus_d.busy, bus_d.result, bus_d.result_valid, bus_d.timeout,
              bus_t.next, bus_t.busy, bus_t.result, bus_t.result_valid, bus_t.timeout};
   endfunction

   function automatic logic [15:0] model_vec();
      return {m_next[0], m_busy[0], m_res[0], m_rv[0], m_to[0],
              m_next[1], m_busy[1], m_res[1], m_rv[1], m_to[1]};
   endfunction

   // One clock: model advances on the active edge, outputs are read on the
   // falling edge, after which the caller drives the next inputs.
   task automatic cycle();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      NRST = 1'b0; NEXT = 1'b1; fin = 1'b0; res = 4'd0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         vectors++;
         if (dut_vec() !== 16'h0) begin
            miscompares++;
            $display("FAIL reset cyc %0d: outputs %h, need 0000", i, dut_vec());
         end
      end
      NRST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_idle edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_clean_press();
      int first_next;
      int n_next;
      first_next = -1;
      n_next     = 0;
      NEXT = 1'b0;
      for (int i = 0; i < 56; i++) begin
         if (i == 20) NEXT = 1'b1;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL clean_press edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_d.next === 1'b1) begin
            if (first_next < 0) first_next = i;
            n_next++;
         end
      end
      vectors++;
      if (first_next !== 6) begin
         miscompares++;
         $display("FAIL press_latency: next after edge %0d, need 6", first_next);
      end
      vectors++;
      if (n_next !== 1) begin
         miscompares++;
         $display("FAIL press_count: %0d next pulses, need 1", n_next);
      end
      fin = 1'b1; res = 4'd7;
      cycle();
      vectors++;
      if (bus_d.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL finish_sample: busy %b, need 1", bus_d.busy);
      end
      cycle();
      vectors++;
      if ({bus_d.busy, bus_d.result, bus_d.result_valid} !== {1'b0, 4'd7, 1'b1}) begin
         miscompares++;
         $display("FAIL finish_latch: busy/result/valid %b/%0d/%b, need 0/7/1",
                  bus_d.busy, bus_d.result, bus_d.result_valid);
      end
      for (int i = 0; i < 6; i++) begin
         if (i == 3) fin = 1'b0;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL clean_tail edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_bounce();
      bit pat [14] = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
      int n_next;
      n_next = 0;
      for (int i = 0; i < 14; i++) begin
         NEXT = pat[i];
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL bounce edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_d.next === 1'b1) n_next++;
      end
      vectors++;
      if (n_next !== 0) begin
         miscompares++;
         $display("FAIL bounce_filtered: %0d next pulses, need 0", n_next);
      end
      n_next = 0;
      for (int i = 0; i < 22; i++) begin
         NEXT = (i < 10) ? 1'b0 : 1'b1;
         fin  = (i >= 16 && i < 19) ? 1'b1 : 1'b0;
         res  = 4'(i % 10);
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL bounce_hold edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_d.next === 1'b1) n_next++;
      end
      vectors++;
      if (n_next !== 1) begin
         miscompares++;
         $display("FAIL bounce_hold_count: %0d next pulses, need 1", n_next);
      end
   endtask

   task automatic test_back_to_back();
      int  n_next;
      bit  saw;
      n_next = 0;
      saw    = 0;
      // Press, re-press 10 cycles into the run, then finish.
      for (int i = 0; i < 40; i++) begin
         NEXT = ((i < 8) || (i >= 16 && i < 24)) ? 1'b0 : 1'b1;
         fin  = (i >= 32 && i < 35) ? 1'b1 : 1'b0;
         res  = 4'd3;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL busy_press edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_d.next === 1'b1) n_next++;
      end
      vectors++;
      if (n_next !== 1 || bus_d.result_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_press_dropped: %0d pulses valid %b, need 1 pulse valid 1",
                  n_next, bus_d.result_valid);
      end
      // Fresh press after the finish.
      for (int i = 0; i < 12; i++) begin
         NEXT = (i < 8) ? 1'b0 : 1'b1;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL repress edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_d.next === 1'b1) saw = 1;
      end
      vectors++;
      if (saw !== 1'b1 || bus_d.result_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL repress: next seen %b valid %b, need 1 and 0", saw, bus_d.result_valid);
      end
      for (int i = 0; i < 6; i++) begin
         fin = (i < 3) ? 1'b1 : 1'b0;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL repress_end edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_timeout();
      int busy_cnt;
      bit saw;
      busy_cnt = 0;
      saw      = 0;
      for (int i = 0; i < 40; i++) begin
         NEXT = (i < 8) ? 1'b0 : 1'b1;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL timeout edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_t.busy === 1'b1) busy_cnt++;
      end
      vectors++;
      if (busy_cnt !== LIM_T || bus_t.timeout !== 1'b1 || bus_t.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_limit: busy %0d cycles timeout %b, need %0d cycles timeout 1",
                  busy_cnt, bus_t.timeout, LIM_T);
      end
      for (int i = 0; i < 18; i++) begin
         NEXT = (i < 8) ? 1'b0 : 1'b1;
         fin  = (i >= 12 && i < 15) ? 1'b1 : 1'b0;
         res  = 4'd9;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL timeout_clear edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_t.next === 1'b1) begin
            saw = 1;
            vectors++;
            if (bus_t.timeout !== 1'b0) begin
               miscompares++;
               $display("FAIL timeout_clear: timeout %b at next, need 0", bus_t.timeout);
            end
         end
      end
      vectors++;
      if (saw !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_repress: no next pulse, need one");
      end
   endtask

   task automatic test_collision();
      int         e;
      bit         hit;
      logic [3:0] res_c;
      e     = -1;
      hit   = 0;
      res_c = 4'($urandom_range(0, 9));
      res   = res_c;
      for (int i = 0; i < 30; i++) begin
         NEXT = (i < 8) ? 1'b0 : 1'b1;
         fin  = (e >= 0 && i - e >= 15 && i - e < 18) ? 1'b1 : 1'b0;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL collision edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (e < 0 && bus_t.next === 1'b1) e = i;
         if (e >= 0 && i - e == 16) begin
            hit = 1;
            vectors++;
            if ({bus_t.busy, bus_t.result, bus_t.result_valid, bus_t.timeout} !==
                {1'b0, res_c, 1'b1, 1'b0}) begin
               miscompares++;
               $display("FAIL collision_finish_wins: busy/result/valid/timeout %b/%0d/%b/%b, need 0/%0d/1/0",
                        bus_t.busy, bus_t.result, bus_t.result_valid, bus_t.timeout, res_c);
            end
         end
      end
      vectors++;
      if (hit !== 1'b1) begin
         miscompares++;
         $display("FAIL collision_setup: limit edge never reached");
      end
      // Finish toggling while idle changes nothing.
      for (int i = 0; i < 12; i++) begin
         fin = (i >= 4 && i < 8) ? 1'b1 : 1'b0;
         res = 4'((res_c + 3) % 10);
         cycle();
         vectors++;
         if ({bus_t.next, bus_t.busy, bus_t.result, bus_t.result_valid, bus_t.timeout} !==
             {1'b0, 1'b0, res_c, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_finish cyc %0d: dut_t outputs changed to %h", i, dut_vec());
         end
      end
   endtask

   task automatic test_reset_midrun();
      int n_next;
      n_next = 0;
      NEXT = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL midrun edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
      end
      NRST = 1'b0;
      cycle();
      vectors++;
      if (dut_vec() !== 16'h0) begin
         miscompares++;
         $display("FAIL midrun_reset: outputs %h, need 0000", dut_vec());
      end
      NRST = 1'b1;
      for (int i = 0; i < 17; i++) begin
         NEXT = (i < 2) ? 1'b0 : 1'b1;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL post_reset edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_d.next === 1'b1 || bus_t.next === 1'b1) n_next++;
      end
      vectors++;
      if (n_next !== 0) begin
         miscompares++;
         $display("FAIL post_reset_quiet: %0d next pulses, need 0", n_next);
      end
      n_next = 0;
      for (int i = 0; i < 18; i++) begin
         NEXT = (i < 8) ? 1'b0 : 1'b1;
         fin  = (i >= 12 && i < 15) ? 1'b1 : 1'b0;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL post_reset_press edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
         if (bus_d.next === 1'b1) n_next++;
      end
      vectors++;
      if (n_next !== 1) begin
         miscompares++;
         $display("FAIL post_reset_press: %0d next pulses, need 1", n_next);
      end
   endtask

   task automatic test_random();
      int hold_b;
      int hold_f;
      hold_b = 0;
      hold_f = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_b == 0) begin
            NEXT   = ~NEXT;
            hold_b = $urandom_range(1, 12);
         end
         if (hold_f == 0) begin
            fin    = ~fin;
            hold_f = $urandom_range(1, 40);
         end
         hold_b--;
         hold_f--;
         res  = 4'($urandom_range(0, 9));
         NRST = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         cycle();
         vectors++;
         if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL random edge %0d: dut %h model %h", edge_no, dut_vec(), model_vec());
         end
      end
      NRST = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      edge_no     = 0;
      m_agree     = 0;
      NRST = 1'b0; NEXT = 1'b1; fin = 1'b0; res = 4'd0;
      @(negedge CLK);
      test_reset();
      test_clean_press();
      test_bounce();
      test_back_to_back();
      test_timeout();
      test_collision();
      test_reset_midrun();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
